// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receiver: FSM states and data-length encoding.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam logic [1:0] BITS_5 = 2'b00;
  localparam logic [1:0] BITS_6 = 2'b01;
  localparam logic [1:0] BITS_7 = 2'b10;
  localparam logic [1:0] BITS_8 = 2'b11;

  function automatic logic [3:0] data_len(input logic [1:0] enc);
    case (enc)
      BITS_5:  return 4'd5;
      BITS_6:  return 4'd6;
      BITS_7:  return 4'd7;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_baud_cnt.sv
// Bit-period counter: wraps every cfg_div+1 clocks and flags the mid-bit count.
module uart_rx_baud_cnt (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic [15:0] div_i,
  output logic        sample_o
);

  logic [15:0] cnt_q;

  // >= rather than == so a divisor lowered while idle cannot strand the count above it
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (cnt_q >= div_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign sample_o = (cnt_q == (div_i >> 1));

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver core: 5-8 data bits, optional even parity (present when UART_RX_PARITY_EN is defined).
// Output handshake: rx_valid_o holds until a cycle with rx_valid_o=1 and rx_ready_i=1; a newer frame overwrites unread data.
module uart_rx_core #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_i,
  input  logic        cfg_en_i,
  input  logic [15:0] cfg_div_i,
  input  logic        cfg_parity_en_i,
  input  logic [1:0]  cfg_bits_i,
  output logic        busy_o,
  output logic        err_o,
  input  logic        err_clr_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i
);
  import uart_rx_pkg::*;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s, rx_prev_q, fall;
  logic                   sample, adv, cnt_clr, par_en, stop_done, last_bit;
  logic [3:0]             len;
  logic [2:0]             bit_cnt_q;
  logic [7:0]             shift_q;
  rx_state_e              state_q, state_n;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_i};
      rx_prev_q <= rx_s;
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign fall = rx_prev_q & ~rx_s;

  uart_rx_baud_cnt u_baud (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (cnt_clr),
    .div_i    (cfg_div_i),
    .sample_o (sample)
  );

`ifdef UART_RX_PARITY_EN
  assign par_en = cfg_parity_en_i;
`else
  logic unused_cfg;
  assign par_en     = 1'b0;
  assign unused_cfg = cfg_parity_en_i ^ err_clr_i;
`endif

  assign len       = data_len(cfg_bits_i);
  assign last_bit  = ({1'b0, bit_cnt_q} == len - 4'd1);
  assign adv       = sample & cfg_en_i;
  assign stop_done = adv && (state_q == ST_STOP);
  assign busy_o    = (state_q != ST_IDLE);

  always_comb begin
    state_n = state_q;
    cnt_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_en_i && fall) begin
          cnt_clr = 1'b1;
          state_n = ST_START;
        end
      end
      ST_START:  if (sample) state_n = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:   if (sample && last_bit) state_n = par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (sample) state_n = ST_STOP;
      ST_STOP:   if (sample) state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
    if (!cfg_en_i) state_n = ST_IDLE;
  end

  // Bits land at their own index, so short frames leave the upper bits zero
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
    end else begin
      state_q <= state_n;
      if (cnt_clr) begin
        bit_cnt_q <= '0;
        shift_q   <= '0;
      end
      if (adv && state_q == ST_DATA) begin
        shift_q[bit_cnt_q] <= rx_s;
        bit_cnt_q          <= bit_cnt_q + 3'd1;
      end
      if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;
      if (stop_done) begin
        rx_data_o  <= shift_q;
        rx_valid_o <= 1'b1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_pend_q, err_q;

  // A set on the same cycle as a clear wins
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      par_pend_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (cnt_clr) par_pend_q <= 1'b0;
      if (adv && state_q == ST_PARITY) par_pend_q <= rx_s ^ (^shift_q);
      if (err_clr_i) err_q <= 1'b0;
      if (stop_done && par_pend_q) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed and randomized frames for uart_rx_core, checked against a frame-level model.
module tb_uart_rx_core;

  localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, rx, en, par_en, err_clr, ready;
  logic [15:0] div;
  logic [1:0]  bits;
  logic        busy, err, valid;
  logic [7:0]  data;

  int          n_vec = 0;
  int          n_miss = 0;
  int          cyc = 0;
  int          rise_cyc = -1;
  int          nval = 0;
  int          nval_start = 0;
  int          exp_rise = 0;
  logic        valid_d = 1'b0;
  logic        exp_err = 1'b0;
  logic [7:0]  exp_q[$];
  logic [7:0]  e1, e2;

  always #5 clk = ~clk;

  uart_rx_core #(.SYNC_STAGES(SYNC)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .rx_i            (rx),
    .cfg_en_i        (en),
    .cfg_div_i       (div),
    .cfg_parity_en_i (par_en),
    .cfg_bits_i      (bits),
    .busy_o          (busy),
    .err_o           (err),
    .err_clr_i       (err_clr),
    .rx_data_o       (data),
    .rx_valid_o      (valid),
    .rx_ready_i      (ready)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Observes valid pulses away from the active edge
  always @(negedge clk) begin
    if (valid && !valid_d) rise_cyc = cyc;
    if (valid) nval++;
    valid_d = valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serialises one frame; expected data/err/valid timing come from the frame rules.
  task automatic send_frame(input logic [7:0] d, input int nb, input bit pe, input bit par_bad);
    logic [7:0] dm;
    bit         pe_eff;
    int         per;
    int         t0;
    per    = int'(div) + 1;
    dm     = d & 8'((1 << nb) - 1);
    pe_eff = pe && PAR_BUILT;
    bits   = 2'(nb - 5);
    par_en = pe;
    exp_q.push_back(dm);
    exp_err    = exp_err | (pe_eff & par_bad);
    nval_start = nval;
    t0         = cyc;
    exp_rise   = t0 + SYNC + 2 + int'(div >> 1) + (nb + 1 + int'(pe_eff)) * per;
    rx = 1'b0;
    tick(per);
    check("busy_in_frame", 32'(busy), 32'd1);
    for (int i = 0; i < nb; i++) begin
      rx = d[i];
      tick(per);
    end
    if (pe) begin
      rx = (^dm) ^ par_bad;
      tick(per);
    end
    rx = 1'b1;
    tick(per + 3);
  endtask

  task automatic check_rx(input logic [7:0] exp_d);
    check("valid_pulse_len", 32'(nval - nval_start), 32'd1);
    check("rx_data", 32'(data), 32'(exp_d));
    check("valid_rise_cycle", 32'(rise_cyc), 32'(exp_rise));
    check("busy_after_frame", 32'(busy), 32'd0);
    check("err", 32'(err), 32'(exp_err));
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    exp_err = 1'b0;
    check("err_cleared", 32'(err), 32'd0);
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; en = 1'b1; div = 16'd16; par_en = 1'b0;
    bits = 2'b11; err_clr = 1'b0; ready = 1'b1;
    tick(3);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_data", 32'(data), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick(5);

    // 8N1 0x41
    send_frame(8'h41, 8, 1'b0, 1'b0);
    check_rx(exp_q.pop_front());

    // 8E1 0x03 with wrong then correct parity
    send_frame(8'h03, 8, 1'b1, 1'b1);
    check_rx(exp_q.pop_front());
    tick(20);
    check("err_sticky", 32'(err), 32'(exp_err));
    clear_err();
    send_frame(8'h03, 8, 1'b1, 1'b0);
    check_rx(exp_q.pop_front());

    // 5N1, bits 1,0,1,1,0 on the wire; garbage in untransmitted MSBs
    send_frame(8'hED, 5, 1'b0, 1'b0);
    check_rx(exp_q.pop_front());

    // Short low glitch: false start
    nval_start = nval;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(2);
    check("glitch_busy_start", 32'(busy), 32'd1);
    tick(20);
    check("glitch_busy_end", 32'(busy), 32'd0);
    check("glitch_no_valid", 32'(nval - nval_start), 32'd0);

    // Overrun with consumer stalled
    ready = 1'b0;
    bits  = 2'b11;
    send_frame(8'h11, 8, 1'b0, 1'b0);
    send_frame(8'h22, 8, 1'b0, 1'b0);
    e1 = exp_q.pop_front();
    e2 = exp_q.pop_front();
    check("overrun_valid", 32'(valid), 32'd1);
    check("overrun_data", 32'(data), 32'(e2));
    ready = 1'b1;
    tick(1);
    check("ready_clears_valid", 32'(valid), 32'd0);

    // Disable mid-frame: abort, retain data
    rx = 1'b0; tick(17);
    rx = 1'b0; tick(17);
    rx = 1'b1; tick(17);
    en = 1'b0;
    tick(1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_data_kept", 32'(data), 32'(e2));
    check("abort_no_valid", 32'(valid), 32'd0);
    tick(5);
    en = 1'b1;
    tick(5);

    // Reset mid-data of 0x55, then 0xA5
    rx = 1'b0; tick(17);
    rx = 1'b1; tick(17);
    rx = 1'b0; tick(17);
    rx = 1'b1; tick(17);
    rx = 1'b0; tick(8);
    rst = 1'b1;
    rx  = 1'b1;
    tick(2);
    exp_err = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_data", 32'(data), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick(5);
    send_frame(8'hA5, 8, 1'b0, 1'b0);
    check_rx(exp_q.pop_front());

    // Randomized frames
    for (int i = 0; i < 8; i++) begin
      logic [7:0] d;
      int         nb;
      bit         pe, bad;
      div = 16'($urandom_range(6, 30));
      nb  = int'($urandom_range(5, 8));
      pe  = 1'($urandom_range(0, 1));
      bad = 1'($urandom_range(0, 1));
      d   = 8'($urandom);
      send_frame(d, nb, pe, bad);
      check_rx(exp_q.pop_front());
      clear_err();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
